// File: rtl/datapath_core.sv
`default_nettype none
// ============================================================================
// Module   : datapath_core
// Purpose  : 8-bit processor datapath. Executes one 37-bit control word per
//            clock: single internal bus, ALU, architectural registers
//            (AR, PC, DR, IR, AC, R1, R2, TR), Z flag and memory port.
// Revision : 1.0  initial release
// ============================================================================
module datapath_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [36:0] ctrl,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  ir,
    output logic        z,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic [7:0]  pc
);

    // Architectural state
    logic [7:0] r_ar, r_pc, r_dr, r_ir, r_ac, r_r1, r_r2, r_tr;
    logic       r_z;

    // Control word fields
    logic [3:0] w_bus_sel;
    logic [3:0] w_alu_op;
    logic       w_ar_ld, w_pc_ld, w_dr_ld, w_ir_ld, w_ac_ld;
    logic       w_r1_ld, w_r2_ld, w_tr_ld;
    logic       w_pc_inc, w_ar_inc, w_ac_inc, w_ac_clr;
    logic       w_mem_rd, w_mem_wr, w_z_en;

    assign w_bus_sel = ctrl[3:0];
    assign w_ar_ld   = ctrl[4];
    assign w_pc_ld   = ctrl[5];
    assign w_dr_ld   = ctrl[6];
    assign w_ir_ld   = ctrl[7];
    assign w_ac_ld   = ctrl[8];
    assign w_r1_ld   = ctrl[9];
    assign w_r2_ld   = ctrl[10];
    assign w_tr_ld   = ctrl[11];
    assign w_pc_inc  = ctrl[12];
    assign w_ar_inc  = ctrl[13];
    assign w_ac_inc  = ctrl[14];
    assign w_ac_clr  = ctrl[15];
    assign w_alu_op  = ctrl[19:16];
    assign w_mem_rd  = ctrl[20];
    assign w_mem_wr  = ctrl[21];
    assign w_z_en    = ctrl[22];

    // Upper control bits belong to the sequencer and carry no meaning here
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^ctrl[36:23];

    logic [7:0] w_bus;
    logic [7:0] w_alu;
    logic [7:0] w_ac_next;
    logic       w_ac_wr;

    // Internal bus source multiplexer; unused selects read as zero
    always_comb begin
        w_bus = 8'h00;
        case (w_bus_sel)
            4'd1:    w_bus = r_pc;
            4'd2:    w_bus = r_dr;
            4'd3:    w_bus = r_ir;
            4'd4:    w_bus = r_ac;
            4'd5:    w_bus = r_r1;
            4'd6:    w_bus = r_r2;
            4'd7:    w_bus = r_tr;
            4'd8:    w_bus = r_ar;
            4'd9:    w_bus = mem_rdata;
            default: w_bus = 8'h00;
        endcase
    end

    // ALU: AC op bus, modulo 256; undefined opcodes leave AC unchanged
    always_comb begin
        w_alu = r_ac;
        case (w_alu_op)
            4'd0:    w_alu = w_bus;
            4'd1:    w_alu = r_ac + w_bus;
            4'd2:    w_alu = r_ac - w_bus;
            4'd3:    w_alu = r_ac & w_bus;
            4'd4:    w_alu = r_ac | w_bus;
            4'd5:    w_alu = r_ac ^ w_bus;
            4'd6:    w_alu = ~r_ac;
            4'd7:    w_alu = {r_ac[6:0], 1'b0};
            4'd8:    w_alu = {1'b0, r_ac[7:1]};
            default: w_alu = r_ac;
        endcase
    end

    // Next AC value with clear > load > increment priority
    always_comb begin
        w_ac_wr   = w_ac_clr | w_ac_ld | w_ac_inc;
        w_ac_next = r_ac;
        if (w_ac_clr)
            w_ac_next = 8'h00;
        else if (w_ac_ld)
            w_ac_next = w_alu;
        else if (w_ac_inc)
            w_ac_next = r_ac + 8'd1;
    end

    // Address and program counters: load beats increment, both wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ar <= 8'h00;
            r_pc <= 8'h00;
        end else begin
            if (w_ar_ld)
                r_ar <= w_bus;
            else if (w_ar_inc)
                r_ar <= r_ar + 8'd1;
            if (w_pc_ld)
                r_pc <= w_bus;
            else if (w_pc_inc)
                r_pc <= r_pc + 8'd1;
        end
    end

    // Data/general registers; a memory read takes precedence over a DR bus load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dr <= 8'h00;
            r_ir <= 8'h00;
            r_r1 <= 8'h00;
            r_r2 <= 8'h00;
            r_tr <= 8'h00;
        end else begin
            if (w_mem_rd)
                r_dr <= mem_rdata;
            else if (w_dr_ld)
                r_dr <= w_bus;
            if (w_ir_ld) r_ir <= w_bus;
            if (w_r1_ld) r_r1 <= w_bus;
            if (w_r2_ld) r_r2 <= w_bus;
            if (w_tr_ld) r_tr <= w_bus;
        end
    end

    // Accumulator and zero flag; Z only tracks AC writes made with z_en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ac <= 8'h00;
            r_z  <= 1'b0;
        end else begin
            if (w_ac_wr)
                r_ac <= w_ac_next;
            if (w_ac_wr && w_z_en)
                r_z <= (w_ac_next == 8'h00);
        end
    end

    assign ir        = r_ir;
    assign z         = r_z;
    assign pc        = r_pc;
    assign mem_addr  = r_ar;
    assign mem_wdata = w_bus;
    assign mem_we    = w_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_datapath_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_core
// Purpose  : Directed self-checking bench for datapath_core.
// Revision : 1.0  initial release
// ============================================================================
module tb_datapath_core;

    logic        clk;
    logic        reset;
    logic [36:0] ctrl;
    logic [7:0]  mem_rdata;
    logic [7:0]  ir, mem_addr, mem_wdata, pc;
    logic        z, mem_we;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [36:0] AR_LD  = 37'd1 << 4;
    localparam logic [36:0] PC_LD  = 37'd1 << 5;
    localparam logic [36:0] DR_LD  = 37'd1 << 6;
    localparam logic [36:0] IR_LD  = 37'd1 << 7;
    localparam logic [36:0] AC_LD  = 37'd1 << 8;
    localparam logic [36:0] R1_LD  = 37'd1 << 9;
    localparam logic [36:0] R2_LD  = 37'd1 << 10;
    localparam logic [36:0] TR_LD  = 37'd1 << 11;
    localparam logic [36:0] PC_INC = 37'd1 << 12;
    localparam logic [36:0] AR_INC = 37'd1 << 13;
    localparam logic [36:0] AC_INC = 37'd1 << 14;
    localparam logic [36:0] AC_CLR = 37'd1 << 15;
    localparam logic [36:0] MEM_RD = 37'd1 << 20;
    localparam logic [36:0] MEM_WR = 37'd1 << 21;
    localparam logic [36:0] Z_EN   = 37'd1 << 22;
    localparam logic [36:0] ALL_LD = AR_LD | PC_LD | DR_LD | IR_LD | AC_LD | R1_LD | R2_LD | TR_LD;

    datapath_core u_dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (ctrl),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .z         (z),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [36:0] bus(input int sel);
        return 37'(sel);
    endfunction

    function automatic logic [36:0] alu(input int op);
        return 37'(op) << 16;
    endfunction

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
        end
    endtask

    // Apply one control word across a rising edge, returning 1 ns after it
    task automatic cyc(input logic [36:0] c, input logic [7:0] d);
        ctrl      = c;
        mem_rdata = d;
        @(posedge clk);
        #1;
        ctrl = '0;
    endtask

    // Read a register through the bus without clocking
    task automatic peek(input int sel, input string tag, input logic [7:0] exp);
        ctrl = bus(sel);
        #1;
        chk(tag, mem_wdata, exp);
        ctrl = '0;
    endtask

    int          ops  [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 15};
    logic [7:0]  exps [10] = '{8'h1D, 8'h69, 8'h42, 8'hDB, 8'h99, 8'h3C, 8'h86, 8'h61, 8'hC3, 8'hC3};

    initial begin
        ctrl      = '0;
        mem_rdata = 8'h00;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        #4;
        chk("por_pc", pc, 8'h00);
        chk("por_ir", ir, 8'h00);
        chk("por_z", {7'b0, z}, 8'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Preload everything nonzero, z=1, then async reset between edges
        cyc(AC_CLR | Z_EN, 8'h00);
        cyc(bus(9) | ALL_LD | alu(0), 8'h5A);
        chk("pre_pc", pc, 8'h5A);
        chk("pre_z", {7'b0, z}, 8'h01);
        #3 reset = 1'b1;
        #2 reset = 1'b0;
        chk("rst_pc", pc, 8'h00);
        chk("rst_ir", ir, 8'h00);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_z", {7'b0, z}, 8'h00);
        peek(2, "rst_dr", 8'h00);
        peek(4, "rst_ac", 8'h00);
        peek(7, "rst_tr", 8'h00);
        @(posedge clk);
        #1;

        // FETCH sequence
        cyc(bus(9) | PC_LD, 8'h10);
        cyc(bus(1) | AR_LD, 8'h00);
        chk("fetch_addr", mem_addr, 8'h10);
        cyc(MEM_RD | PC_INC, 8'hB0);
        chk("fetch_pc", pc, 8'h11);
        peek(2, "fetch_dr", 8'hB0);
        cyc(bus(2) | IR_LD, 8'h00);
        chk("fetch_ir", ir, 8'hB0);

        // SUB to zero, then 0x00 - 0x05
        cyc(bus(9) | AC_LD | alu(0), 8'h40);
        cyc(bus(9) | DR_LD, 8'h40);
        cyc(bus(2) | alu(2) | AC_LD | Z_EN, 8'h00);
        peek(4, "sub0_ac", 8'h00);
        chk("sub0_z", {7'b0, z}, 8'h01);
        cyc(bus(9) | DR_LD, 8'h05);
        cyc(bus(2) | alu(2) | AC_LD | Z_EN, 8'h00);
        peek(4, "sub5_ac", 8'hFB);
        chk("sub5_z", {7'b0, z}, 8'h00);
        // Read-modify: AC + AC uses old AC
        cyc(bus(4) | alu(1) | AC_LD, 8'h00);
        peek(4, "dbl_ac", 8'hF6);

        // ALU op table: AC=0xC3 op bus=0x5A
        for (int i = 0; i < 10; i++) begin
            cyc(bus(9) | AC_LD | alu(0), 8'hC3);
            cyc(bus(9) | AC_LD | alu(ops[i]), 8'h5A);
            peek(4, $sformatf("alu_op%0d", ops[i]), exps[i]);
        end

        // Priority and wrap
        cyc(bus(9) | PC_LD, 8'hFF);
        cyc(PC_INC, 8'h00);
        chk("pc_wrap", pc, 8'h00);
        cyc(bus(9) | PC_LD | PC_INC, 8'h20);
        chk("pc_ld_prio", pc, 8'h20);
        cyc(bus(9) | AR_LD | AR_INC, 8'hFF);
        chk("ar_ld_prio", mem_addr, 8'hFF);
        cyc(AR_INC, 8'h00);
        chk("ar_wrap", mem_addr, 8'h00);
        cyc(bus(9) | AC_CLR | AC_LD | AC_INC, 8'h77);
        peek(4, "ac_clr_prio", 8'h00);
        cyc(bus(1) | MEM_RD | DR_LD, 8'h99);
        peek(2, "dr_rd_prio", 8'h99);

        // Z hold behaviour (z currently 0)
        cyc(bus(9) | AC_LD | alu(0), 8'hFF);
        cyc(AC_INC, 8'h00);
        peek(4, "inc_wrap_ac", 8'h00);
        chk("zhold_noen", {7'b0, z}, 8'h00);
        cyc(AC_CLR | Z_EN, 8'h00);
        cyc(bus(9) | AC_LD | alu(0), 8'h11);
        cyc(Z_EN, 8'h00);
        chk("zhold_nowr", {7'b0, z}, 8'h01);
        cyc(AC_INC | Z_EN, 8'h00);
        peek(4, "inc_ac", 8'h12);
        chk("zinc_clr", {7'b0, z}, 8'h00);
        cyc(bus(9) | AC_LD | alu(0), 8'hFF);
        cyc(AC_INC | Z_EN, 8'h00);
        chk("zinc_wrap", {7'b0, z}, 8'h01);

        // Memory write strobe and write data
        ctrl      = bus(9) | MEM_WR;
        mem_rdata = 8'h3C;
        #1;
        chk("we_on", {7'b0, mem_we}, 8'h01);
        chk("wdata", mem_wdata, 8'h3C);
        ctrl = '0;

        // Ignored upper bits: no state change over 5 cycles
        cyc(bus(9) | ALL_LD | alu(0), 8'hA5);
        for (int i = 0; i < 5; i++) begin
            ctrl      = {14'h3FFF, 23'h0};
            mem_rdata = 8'h00;
            #1;
            chk("hi_we", {7'b0, mem_we}, 8'h00);
            @(posedge clk);
            #1;
        end
        ctrl = '0;
        chk("hi_pc", pc, 8'hA5);
        chk("hi_ir", ir, 8'hA5);
        chk("hi_addr", mem_addr, 8'hA5);
        chk("hi_z", {7'b0, z}, 8'h01);
        peek(2, "hi_dr", 8'hA5);
        peek(4, "hi_ac", 8'hA5);
        peek(5, "hi_r1", 8'hA5);
        peek(6, "hi_r2", 8'hA5);
        peek(7, "hi_tr", 8'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/datapath_core.md
# datapath_core

8-bit processor datapath driven by the 37-bit control word from `ctrlu_top`, and the producer of the `ir` and `z` inputs that `ctrlu_top` consumes. It holds the architectural registers (AR, PC, DR, IR, AC, R1, R2, TR), a single internal bus, an ALU, a Z flag, and the memory port. One control word is executed per clock.

## Interface
- No parameters. Data and address width is fixed at 8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ctrl`  in  37  control word from `ctrlu_top`. Bits [22:0] are decoded here; bits [36:23] are ignored.
- `mem_rdata`  in  8  memory read data, valid in the same cycle as `mem_rd`.
- `ir`  out  8  instruction register, to `ctrlu_top`.
- `z`  out  1  zero flag, to `ctrlu_top`.
- `mem_addr`  out  8  equals AR, driven from the register.
- `mem_wdata`  out  8  current bus value.
- `mem_we`  out  1  equals `ctrl[21]`.
- `pc`  out  8  PC, for debug and bench visibility.

## Operation
Control word fields:
- [3:0] `bus_sel`:
  - 0: 0x00
  - 1: PC
  - 2: DR
  - 3: IR
  - 4: AC
  - 5: R1
  - 6: R2
  - 7: TR
  - 8: AR
  - 9: `mem_rdata`
  - 10–15: 0x00
- Load enables, each taking the bus value: [4] ar_ld, [5] pc_ld, [6] dr_ld, [7] ir_ld, [8] ac_ld, [9] r1_ld, [10] r2_ld, [11] tr_ld. Exception: ac_ld takes the ALU result, not the bus.
- [12] pc_inc, [13] ar_inc, [14] ac_inc, [15] ac_clr.
- [19:16] `alu_op`:
  - 0: pass bus
  - 1: AC+bus
  - 2: AC−bus
  - 3: AND
  - 4: OR
  - 5: XOR
  - 6: ~AC
  - 7: AC<<1
  - 8: AC>>1 (logical)
  - 9–15: pass AC
- [20] mem_rd: DR <= `mem_rdata`.
- [21] mem_wr.
- [22] z_en.

Rules:
- Bus is a combinational mux; all register writes are registered.
- Arithmetic is modulo 256; carry and borrow are discarded. Example: AC=0x03, SUB with bus 0x05 gives 0xFE.
- PC and AR increment wraps 0xFF → 0x00. AC increment also wraps.
- Same-register priority:
  - PC: pc_ld > pc_inc.
  - AR: ar_ld > ar_inc.
  - DR: mem_rd > dr_ld.
  - AC: ac_clr > ac_ld > ac_inc.
- Any number of different registers may load in the same cycle, all from the same bus value.
- Z: when z_en=1 and AC is written (clr, ld or inc), z <= (new AC == 0). z holds otherwise, including when z_en=1 with no AC write.
- An all-zero control word is a no-op: all state holds.
- `mem_we` is combinational from `ctrl`. It is not gated by reset.

## Timing
- Reset: AR, PC, DR, IR, AC, R1, R2, TR = 0x00 and z = 0, immediately on `reset` rising, independent of `clk`. Therefore `ir` = 0x00 after reset, which the control unit decodes as the FETCH path.
- Latency: the control word present during cycle n is executed at the rising edge ending cycle n. Updated `ir`, `z`, `pc` and `mem_addr` are visible after that edge, in time for `ctrlu_top` to sample them at the next edge.
- Read-modify timing: a register read onto the bus and written in the same cycle uses its old value. Example: bus=AC with ac_ld and alu_op=1 doubles AC.
- Memory writes use `mem_addr`=AR as it stood before the edge.
- `mem_rdata` must be stable before the rising edge in any cycle with mem_rd=1.
- Reset asserted mid-instruction discards all in-flight state. The first edge after release executes the control word present at that edge.

## Test plan
- Reset: preload all registers with nonzero values, then pulse `reset` between clock edges → all outputs 0x00 and z=0 before the next edge; `mem_addr`=0.
- FETCH:
  - Cycle 1: PC=0x10, ctrl bus_sel=1 with ar_ld → `mem_addr`=0x10.
  - Cycle 2: mem_rd, pc_inc, `mem_rdata`=0xB0 → DR=0xB0, PC=0x11.
  - Cycle 3: bus_sel=2 with ir_ld → `ir`=0xB0.
- SUB to zero: AC=0x40, DR=0x40, bus_sel=2, alu_op=2, ac_ld, z_en → AC=0x00, z=1. Repeat with DR=0x05 → AC=0xFB, z=0.
- Priority and wrap:
  - PC=0xFF with pc_inc alone → PC=0x00.
  - pc_ld and pc_inc with bus=0x20 → PC=0x20.
  - ac_clr, ac_ld and ac_inc together → AC=0x00.
  - mem_rd and dr_ld together → DR=`mem_rdata`.
- Z hold: ac_inc without z_en giving AC=0 → z unchanged; z_en without any AC write → z unchanged.
- Ignored bits: ctrl[36:23] all ones with [22:0]=0 → no state change for 5 cycles; `mem_we`=0.
